riscv_run_ctrl: RTL and testbench
=================================

# riscv_run_ctrl

Parametrised run/debug controller between the board push-buttons and the multicycle RISC-V core. It supersedes the bare Run/Continue handling with a synchronised, edge-detected Continue, three halt modes (pause-state, single-step, PC breakpoint), up to NUM_BP breakpoint channels and a retired-instruction counter. It drives a single hold line into the core FSM and exposes status for LED/HEX display.

## Interface
- XLEN, 32, PC/breakpoint width
- NUM_BP, 4, breakpoint channels (1..8)
- SYNC_STAGES, 2, Continue synchroniser depth (>=2)
- CNT_W, 32, retired-instruction counter width
- Clk  in  1  system clock, all logic on rising edge
- Run  in  1  synchronous, active-low reset (board Run button)
- Continue  in  1  active-low button, asynchronous to Clk
- mode_i  in  2  00 pause-run, 01 single-step, 10 breakpoint-run, 11 = 10 plus pause halts
- pause_req_i  in  1  level, high while core sits in an IO pause state
- retire_i  in  1  one-cycle pulse per completed instruction
- pc_i  in  XLEN  PC of next instruction, valid with retire_i
- bp_addr_i  in  NUM_BP*XLEN  breakpoint addresses, channel k at [k*XLEN +: XLEN]
- bp_en_i  in  NUM_BP  per-channel enable
- hold_o  out  1  core stalls while 1
- cause_o  out  3  sticky halt cause: [0] pause, [1] step, [2] breakpoint
- bp_hit_o  out  NUM_BP  sticky matching channels
- retired_o  out  CNT_W  retired-instruction count
- state_o  out  2  current FSM state encoding

## Operation
- Reset (Run=0 at an edge): state RUN, hold_o=0, cause_o=0, bp_hit_o=0, retired_o=0, synchroniser flops=1 (released), pause-edge flop=0.
- Continue passes SYNC_STAGES flops; press event = synced 1->0 transition; release = synced level 1.
- States: RUN (hold 0), HALT (hold 1), WAIT_REL (hold 1).
- RUN -> HALT when any trigger fires in the same cycle:
  - pause trigger: rising edge of pause_req_i, modes 00 and 11 only.
  - step trigger: retire_i, mode 01.
  - bp trigger: retire_i and bp_en_i[k] and pc_i==bp_addr_i[k] for any k, modes 10/11.
  - all simultaneous triggers are recorded in cause_o / bp_hit_o (OR, no priority).
- HALT -> WAIT_REL on press event. WAIT_REL -> RUN when synced Continue is 1; cause_o and bp_hit_o clear on that transition.
- Press events in RUN and WAIT_REL are ignored.
- mode_i is sampled every cycle; changing it while halted affects only the next RUN period.
- retired_o increments on every retire_i in any state, saturates at all-ones (no wrap).
- pause_req_i still high after resume does not re-trigger (edge only).
- Reset mid-operation overrides all: returns to RUN with the reset values above.

## Timing
- Trigger sampled at edge n -> hold_o=1 from edge n+1 (one-cycle registered latency; core must allow one extra state transition after retire_i).
- Button press to WAIT_REL: SYNC_STAGES+1 cycles; release to hold_o=0: SYNC_STAGES+1 cycles.
- retired_o updated the cycle after retire_i.
- Breakpoint compare is combinational into the state register; no pipelining.

## Structure
- Package riscv_dbg_pkg: state enum (RUN, HALT, WAIT_REL), mode constants, cause bit indices.
- Sub-module dbg_sync: SYNC_STAGES synchroniser plus falling-edge detector, outputs level and press pulse.
- Top holds FSM, breakpoint comparator array (generate loop), counter.

## Test plan
- Reset then mode 00, pause_req_i rises at cycle 10 -> hold_o=1 at cycle 11, cause_o=001; press/release Continue -> hold_o=0 after SYNC_STAGES+1 cycles, cause_o=000, pause_req_i still high does not re-halt.
- Mode 01, three retire_i pulses each followed by press/release -> exactly three halts, cause_o=010 each, retired_o=3.
- Mode 10, bp_addr_i ch0=0x0000_0040, ch2=0x0000_0040, both enabled, retire_i with pc_i=0x40 -> bp_hit_o=0101, cause_o=100; same pc with bp_en_i=0 -> no halt.
- Mode 11, pause_req_i rising edge and matching retire_i in same cycle -> cause_o=101, single HALT entry.
- Continue glitch held low only while in RUN -> no state change; Run=0 while in WAIT_REL -> RUN, hold_o=0, retired_o=0 next cycle.
- CNT_W=4, 20 retire_i pulses -> retired_o saturates at 15.

Source files
------------

// File: rtl/riscv_dbg_pkg.sv
// Shared types and constants for the RISC-V run/debug controller.
package riscv_dbg_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StHalt    = 2'd1,
        StWaitRel = 2'd2
    } run_state_e;

    localparam logic [1:0] ModePauseRun = 2'b00;
    localparam logic [1:0] ModeStep     = 2'b01;
    localparam logic [1:0] ModeBpRun    = 2'b10;
    localparam logic [1:0] ModeBpPause  = 2'b11;

    localparam int unsigned CauseW        = 3;
    localparam int unsigned CauseIdxPause = 0;
    localparam int unsigned CauseIdxStep  = 1;
    localparam int unsigned CauseIdxBp    = 2;

    function automatic logic mode_pause_en(input logic [1:0] mode);
        return (mode == ModePauseRun) || (mode == ModeBpPause);
    endfunction

    function automatic logic mode_bp_en(input logic [1:0] mode);
        return (mode == ModeBpRun) || (mode == ModeBpPause);
    endfunction

endpackage

// File: rtl/dbg_sync.sv
// Multi-flop synchroniser for an active-low button, with a falling-edge (press) detector.
module dbg_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic level_o,
    output logic press_o
);

    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic                   prev_d, prev_q;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_ni};
        prev_d  = sync_q[SYNC_STAGES-1];
        level_o = sync_q[SYNC_STAGES-1];
        press_o = prev_q & ~sync_q[SYNC_STAGES-1];
    end

    // Reset to the released level so a held button cannot fake a press out of reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/riscv_run_ctrl.sv
// Run/debug controller: halts the multicycle core on pause, single-step or PC breakpoint,
// resumes on a synchronised Continue press/release, and counts retired instructions.
module riscv_run_ctrl
    import riscv_dbg_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_BP      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   Clk,
    input  logic                   Run,
    input  logic                   Continue,
    input  logic [1:0]             mode_i,
    input  logic                   pause_req_i,
    input  logic                   retire_i,
    input  logic [XLEN-1:0]        pc_i,
    input  logic [NUM_BP*XLEN-1:0] bp_addr_i,
    input  logic [NUM_BP-1:0]      bp_en_i,
    output logic                   hold_o,
    output logic [CauseW-1:0]      cause_o,
    output logic [NUM_BP-1:0]      bp_hit_o,
    output logic [CNT_W-1:0]       retired_o,
    output logic [1:0]             state_o
);

    logic cont_level, cont_press;

    dbg_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (Clk),
        .rst_ni (Run),
        .btn_ni (Continue),
        .level_o(cont_level),
        .press_o(cont_press)
    );

    logic [NUM_BP-1:0] bp_match;

    for (genvar k = 0; k < NUM_BP; k++) begin : g_bp
        assign bp_match[k] = bp_en_i[k] && (pc_i == bp_addr_i[k*XLEN +: XLEN]);
    end

    run_state_e        state_d, state_q;
    logic              hold_d, hold_q;
    logic [CauseW-1:0] cause_d, cause_q;
    logic [NUM_BP-1:0] bp_hit_d, bp_hit_q;
    logic [CNT_W-1:0]  retired_d, retired_q;
    logic              pause_d, pause_q;
    logic [CauseW-1:0] trig;

    always_comb begin
        pause_d = pause_req_i;

        trig                = '0;
        trig[CauseIdxPause] = pause_req_i & ~pause_q & mode_pause_en(mode_i);
        trig[CauseIdxStep]  = retire_i & (mode_i == ModeStep);
        trig[CauseIdxBp]    = retire_i & (|bp_match) & mode_bp_en(mode_i);

        state_d  = state_q;
        cause_d  = cause_q;
        bp_hit_d = bp_hit_q;

        unique case (state_q)
            StRun: begin
                // Simultaneous triggers are all recorded; no priority between them.
                if (|trig) begin
                    state_d  = StHalt;
                    cause_d  = cause_q | trig;
                    bp_hit_d = bp_hit_q | (trig[CauseIdxBp] ? bp_match : '0);
                end
            end
            StHalt: begin
                if (cont_press) begin
                    state_d = StWaitRel;
                end
            end
            StWaitRel: begin
                if (cont_level) begin
                    state_d  = StRun;
                    cause_d  = '0;
                    bp_hit_d = '0;
                end
            end
            default: state_d = StRun;
        endcase

        hold_d = (state_d != StRun);

        retired_d = retired_q;
        if (retire_i && (retired_q != '1)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Run) begin
            state_q   <= StRun;
            hold_q    <= 1'b0;
            cause_q   <= '0;
            bp_hit_q  <= '0;
            retired_q <= '0;
            pause_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cause_q   <= cause_d;
            bp_hit_q  <= bp_hit_d;
            retired_q <= retired_d;
            pause_q   <= pause_d;
        end
    end

    assign hold_o    = hold_q;
    assign cause_o   = cause_q;
    assign bp_hit_o  = bp_hit_q;
    assign retired_o = retired_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Scoreboard bench for riscv_run_ctrl: per-cycle expectations from a behavioural model.
module tb_riscv_run_ctrl;

    localparam int XLEN   = 32;
    localparam int NUM_BP = 4;
    localparam int S      = 2;

    logic                   clk = 1'b0;
    logic                   run, cont, pause, retire;
    logic [1:0]             mode;
    logic [XLEN-1:0]        pc;
    logic [NUM_BP*XLEN-1:0] bp_addr;
    logic [NUM_BP-1:0]      bp_en;

    logic              hold, hold4;
    logic [2:0]        cause, cause4;
    logic [NUM_BP-1:0] bp_hit, bp_hit4;
    logic [31:0]       retired;
    logic [3:0]        retired4;
    logic [1:0]        state, state4;

    always #5 clk = ~clk;

    riscv_run_ctrl #(
        .XLEN(XLEN), .NUM_BP(NUM_BP), .SYNC_STAGES(S), .CNT_W(32)
    ) dut (
        .Clk(clk), .Run(run), .Continue(cont), .mode_i(mode), .pause_req_i(pause),
        .retire_i(retire), .pc_i(pc), .bp_addr_i(bp_addr), .bp_en_i(bp_en),
        .hold_o(hold), .cause_o(cause), .bp_hit_o(bp_hit), .retired_o(retired),
        .state_o(state)
    );

    riscv_run_ctrl #(
        .XLEN(XLEN), .NUM_BP(NUM_BP), .SYNC_STAGES(S), .CNT_W(4)
    ) dut4 (
        .Clk(clk), .Run(run), .Continue(cont), .mode_i(mode), .pause_req_i(pause),
        .retire_i(retire), .pc_i(pc), .bp_addr_i(bp_addr), .bp_en_i(bp_en),
        .hold_o(hold4), .cause_o(cause4), .bp_hit_o(bp_hit4), .retired_o(retired4),
        .state_o(state4)
    );

    typedef struct packed {
        logic [41:0] main;
        logic [13:0] aux;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: state 0 running, 1 halted, 2 waiting for button release.
    int     m_st;
    bit [2:0] m_cause;
    bit [3:0] m_bp;
    longint m_cnt;
    int     m_cnt4;
    bit     m_pprev;
    bit     hist[$];

    function automatic void model_step();
        bit       lvl, lprev, press, prise, tp, ts, tb;
        bit [3:0] hits;
        exp_t     e;
        if (!run) begin
            m_st = 0; m_cause = 0; m_bp = 0; m_cnt = 0; m_cnt4 = 0; m_pprev = 0;
            hist = {};
            for (int i = 0; i <= S; i++) hist.push_back(1'b1);
        end else begin
            lvl   = hist[S-1];
            lprev = hist[S];
            press = lprev && !lvl;
            prise = pause && !m_pprev;
            hits  = '0;
            for (int k = 0; k < NUM_BP; k++)
                if (retire && bp_en[k] && pc == bp_addr[k*XLEN +: XLEN]) hits[k] = 1'b1;
            tp = prise && (mode == 2'b00 || mode == 2'b11);
            ts = retire && mode == 2'b01;
            tb = (hits != 0) && mode[1];
            if (m_st == 0) begin
                if (tp || ts || tb) begin
                    m_st = 1; m_cause = {tb, ts, tp}; m_bp = tb ? hits : 4'b0;
                end
            end else if (m_st == 1) begin
                if (press) m_st = 2;
            end else begin
                if (lvl) begin m_st = 0; m_cause = 0; m_bp = 0; end
            end
            if (retire) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            m_pprev = pause;
            hist.push_front(cont);
            void'(hist.pop_back());
        end
        e.main = {m_st != 0, m_cause, m_bp, m_cnt[31:0], 2'(m_st)};
        e.aux  = {m_st != 0, m_cause, m_bp, 4'(m_cnt4), 2'(m_st)};
        q.push_back(e);
    endfunction

    always @(posedge clk) begin
        exp_t        e;
        logic [41:0] am;
        logic [13:0] aa;
        #1;
        if (q.size() > 0) begin
            e  = q.pop_front();
            am = {hold, cause, bp_hit, retired, state};
            aa = {hold4, cause4, bp_hit4, retired4, state4};
            n_checks++;
            if (am === e.main) n_pass++;
            else $display("FAIL main cyc=%0d got hold/cause/bp/ret/st=%h want %h", cyc, am, e.main);
            n_checks++;
            if (aa === e.aux) n_pass++;
            else $display("FAIL cnt4 cyc=%0d got hold/cause/bp/ret/st=%h want %h", cyc, aa, e.aux);
            cyc++;
        end
    end

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic press_release();
        cont = 1'b0; idle(4);
        cont = 1'b1; idle(5);
    endtask

    task automatic retire_at(input logic [XLEN-1:0] a);
        retire = 1'b1; pc = a; tick();
        retire = 1'b0;
    endtask

    initial begin
        run = 1'b0; cont = 1'b1; pause = 1'b0; retire = 1'b0; mode = 2'b00; pc = '0;
        bp_addr = {32'h0000_0200, 32'h0000_0040, 32'h0000_0044, 32'h0000_0040};
        bp_en = '0;
        @(negedge clk);
        idle(3);
        run = 1'b1;

        // Pause-run: edge-triggered halt, resume with pause still high.
        idle(9);
        pause = 1'b1; idle(3);
        press_release();
        idle(6);
        pause = 1'b0; idle(2);

        // Single-step: three halts.
        mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            retire_at(32'h100 + 32'(4 * i));
            idle(2);
            press_release();
        end

        // Breakpoint channels 0 and 2 on the same address, then disabled.
        mode = 2'b10; bp_en = 4'b0101;
        retire_at(32'h40); idle(2);
        press_release();
        bp_en = 4'b0000;
        retire_at(32'h40); idle(3);

        // Pause edge and breakpoint in the same cycle.
        mode = 2'b11; bp_en = 4'b0101;
        pause = 1'b1; retire_at(32'h40); idle(2);
        press_release();
        pause = 1'b0;

        // Continue glitch while running, then reset out of WAIT_REL.
        cont = 1'b0; idle(3); cont = 1'b1; idle(4);
        mode = 2'b01; retire_at(32'h80); idle(1);
        cont = 1'b0; idle(4);
        run = 1'b0; idle(1);
        run = 1'b1; cont = 1'b1; idle(3);

        // Counter saturation on the narrow instance.
        mode = 2'b10; bp_en = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            retire_at(32'h300); idle(1);
        end

        // Randomised traffic.
        bp_en = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            if ($urandom_range(0, 5) == 0) cont = ~cont;
            if ($urandom_range(0, 19) == 0) bp_en = 4'($urandom);
            retire = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: pc = 32'h40;
                1: pc = 32'h44;
                2: pc = 32'h200;
                default: pc = $urandom;
            endcase
            run = ($urandom_range(0, 299) != 0);
            tick();
        end
        run = 1'b1; retire = 1'b0;
        idle(2);

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
